// File: rtl/ok_sim_pkg.sv
// ok_sim_pkg: shared FSM state, record type and sizing helper for the collector
package ok_sim_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} done_state_t;

   localparam int REC_CH_W   = 3;
   localparam int REC_DATA_W = 32;

   typedef struct packed {
      logic [REC_CH_W-1:0]   chan;
      logic [REC_DATA_W-1:0] data;
   } ok_rec_t;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ok_sync_fifo.sv
// ok_sync_fifo: first-word-fall-through FIFO with wrap-bit pointers and live occupancy
module ok_sync_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DATA_W-1:0]       din,
   output logic [DATA_W-1:0]       dout,
   output logic                    valid,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr, rd;
   logic              do_push, do_pop;

   assign count   = wr - rd;
   assign valid   = wr != rd;
   assign full    = count == (AW+1)'(DEPTH);
   assign do_push = push && !full;
   assign do_pop  = pop && valid;
   // empty head reads as zero so a reset never exposes stale storage
   assign dout    = valid ? mem[rd[AW-1:0]] : '0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr <= '0;
         rd <= '0;
      end else begin
         if (do_push) wr <= wr + 1'b1;
         if (do_pop)  rd <= rd + 1'b1;
      end

   always_ff @(posedge clk)
      if (do_push) mem[wr[AW-1:0]] <= din;

endmodule

// File: rtl/ok_multi_host_collector.sv
// ok_multi_host_collector: round-robin merge of host channels into a tagged FIFO
// with a quiescence-based done detector
module ok_multi_host_collector
   import ok_sim_pkg::*;
#(
   parameter int NUM_HOSTS   = 2,
   parameter int DATA_W      = 32,
   parameter int FIFO_DEPTH  = 16,
   parameter int IDLE_CYCLES = 8,
   parameter int CH_W        = clog2_min1(NUM_HOSTS)
) (
   input  logic                          okClk,
   input  logic                          rst_n,
   input  logic [NUM_HOSTS-1:0]          ch_valid,
   input  logic [NUM_HOSTS*DATA_W-1:0]   ch_data,
   output logic [NUM_HOSTS-1:0]          ch_ready,
   input  logic                          start,
   output logic                          evt_valid,
   output logic [DATA_W-1:0]             evt_data,
   output logic [CH_W-1:0]               evt_chan,
   input  logic                          evt_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          ok_done
);
   localparam int CW = $clog2(IDLE_CYCLES + 1);

   done_state_t              state;
   logic [CH_W-1:0]          rr, sel;
   logic [DATA_W-1:0]        sel_data;
   logic [2*NUM_HOSTS-1:0]   rot;
   logic [CH_W+DATA_W-1:0]   head;
   logic [CW-1:0]            cnt, cnt_nxt;
   logic                     full, push, quiet;

   // rotate so bit k of rot is channel (rr+k) mod N; the lowest set bit wins
   assign rot = {ch_valid, ch_valid} >> rr;

   always_comb begin
      sel = '0;
      sel_data = '0;
      for (int k = NUM_HOSTS - 1; k >= 0; k--)
         if (rot[k]) sel = CH_W'((int'(rr) + k) % NUM_HOSTS);
      for (int k = 0; k < NUM_HOSTS; k++)
         if (sel == CH_W'(k)) sel_data = ch_data[k*DATA_W +: DATA_W];
   end

   assign push     = (|ch_valid) && !full;
   assign ch_ready = push ? NUM_HOSTS'(1) << sel : '0;
   assign quiet    = (ch_valid == '0) && (fifo_count == '0) && !push;
   assign cnt_nxt  = quiet ? cnt + 1'b1 : '0;

   ok_sync_fifo #(.DATA_W(CH_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (okClk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (evt_ready),
      .din   ({sel, sel_data}),
      .dout  (head),
      .valid (evt_valid),
      .full  (full),
      .count (fifo_count)
   );

   assign {evt_chan, evt_data} = head;

   always_ff @(posedge okClk or negedge rst_n)
      if (!rst_n) rr <= '0;
      else if (push) rr <= (sel == CH_W'(NUM_HOSTS - 1)) ? '0 : sel + 1'b1;

   always_ff @(posedge okClk or negedge rst_n)
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         ok_done <= 1'b0;
      end else begin
         case (state)
            S_IDLE:
               if (start) begin
                  state <= S_RUN;
                  cnt   <= '0;
               end
            S_RUN:
               if (start) cnt <= '0;
               else begin
                  cnt <= cnt_nxt;
                  if (cnt_nxt == CW'(IDLE_CYCLES)) begin
                     state   <= S_DONE;
                     ok_done <= 1'b1;
                  end
               end
            S_DONE:
               if (start || (|ch_valid)) begin
                  state   <= S_RUN;
                  cnt     <= '0;
                  ok_done <= 1'b0;
               end
            default: state <= S_IDLE;
         endcase
      end

endmodule

// File: tb/tb_ok_multi_host_collector.sv
// tb_ok_multi_host_collector: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the collector
module tb_ok_multi_host_collector;
   localparam int NH    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int IDLE  = 8;

   logic            okClk = 1'b0, rst_n = 1'b0, start = 1'b0, evt_ready = 1'b0;
   logic [NH-1:0]   ch_valid = '0;
   logic [NH-1:0]   ch_ready;
   logic [NH*DW-1:0] ch_data = '0;
   logic            evt_valid, ok_done;
   logic [DW-1:0]   evt_data;
   logic [1:0]      evt_chan;
   logic [4:0]      fifo_count;

   int n_cmp = 0, n_err = 0;

   typedef struct {int chan; logic [DW-1:0] data;} rec_t;
   rec_t q[$];
   int   m_rr = 0, streak = 0, last_g = -1;
   bit   armed = 0;
   bit   obs_pop, obs_done;
   logic [DW-1:0] obs_data;
   logic [NH-1:0] obs_grant;

   always #5 okClk = ~okClk;

   ok_multi_host_collector #(
      .NUM_HOSTS(NH), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .IDLE_CYCLES(IDLE)
   ) dut (
      .okClk(okClk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data),
      .ch_ready(ch_ready), .start(start), .evt_valid(evt_valid), .evt_data(evt_data),
      .evt_chan(evt_chan), .evt_ready(evt_ready), .fifo_count(fifo_count), .ok_done(ok_done)
   );

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // next grant from the rules: first valid channel at or after rr, none when full
   function automatic int pick();
      if (q.size() >= DEPTH) return -1;
      for (int k = 0; k < NH; k++)
         if (ch_valid[(m_rr + k) % NH]) return (m_rr + k) % NH;
      return -1;
   endfunction

   task automatic model_reset();
      q.delete();
      m_rr = 0;
      streak = 0;
      armed = 0;
      last_g = -1;
   endtask

   // one clock: check everything at the falling edge, then advance the model
   task automatic step(string tag);
      int g;
      bit quiet;
      @(negedge okClk);
      g = pick();
      chk({tag, ".ready"}, 64'(ch_ready), g < 0 ? 64'd0 : 64'd1 << g);
      chk({tag, ".valid"}, 64'(evt_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         chk({tag, ".data"}, 64'(evt_data), 64'(q[0].data));
         chk({tag, ".chan"}, 64'(evt_chan), 64'(q[0].chan));
      end
      chk({tag, ".count"}, 64'(fifo_count), 64'(q.size()));
      chk({tag, ".done"}, 64'(ok_done), 64'(armed && streak >= IDLE));
      obs_pop = evt_valid && evt_ready;
      obs_data = evt_data;
      obs_done = ok_done;
      obs_grant = ch_ready;
      quiet = (ch_valid == '0) && (q.size() == 0);
      if (evt_ready && q.size() != 0) q.delete(0);
      if (g >= 0) begin
         q.push_back('{g, ch_data[g*DW +: DW]});
         m_rr = (g + 1) % NH;
      end
      if (start) begin
         armed = 1;
         streak = 0;
      end else if (armed) begin
         if (streak >= IDLE) begin
            if (ch_valid != '0) streak = 0;
         end else streak = quiet ? streak + 1 : 0;
      end
      last_g = g;
      @(posedge okClk);
      #1;
   endtask

   task automatic hard_reset();
      ch_valid = '0;
      start = 0;
      evt_ready = 0;
      rst_n = 0;
      model_reset();
      @(posedge okClk);
      #1 rst_n = 1;
      @(posedge okClk);
      #1;
   endtask

   task automatic drain();
      ch_valid = '0;
      start = 0;
      evt_ready = 1;
      for (int i = 0; i < 3*DEPTH && q.size() != 0; i++) step("drain");
      chk("drain.empty", 64'(fifo_count), 0);
   endtask

   task automatic refresh(int pct);
      for (int c = 0; c < NH; c++)
         if (last_g == c || (ch_valid[c] && $urandom_range(99) < 3)) ch_valid[c] = 1'b0;
         else if (!ch_valid[c] && $urandom_range(99) < pct) begin
            ch_valid[c] = 1'b1;
            ch_data[c*DW +: DW] = $urandom;
         end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int n, exp_seq, nxt, len, pct, rdp;
      int cnt [NH];
      logic [DW-1:0] v;
      repeat (3) @(posedge okClk);
      #1;
      chk("rst.ready", 64'(ch_ready), 0);
      chk("rst.valid", 64'(evt_valid), 0);
      chk("rst.data", 64'(evt_data), 0);
      chk("rst.chan", 64'(evt_chan), 0);
      chk("rst.count", 64'(fifo_count), 0);
      chk("rst.done", 64'(ok_done), 0);
      rst_n = 1;
      @(posedge okClk);
      #1;

      ch_valid = 4'b0001;
      ch_data[0 +: DW] = 32'hDEADBEEF;
      evt_ready = 1;
      step("single.grant");
      chk("single.ready", 64'(obs_grant), 1);
      ch_valid = '0;
      step("single.out");
      chk("single.data", 64'(obs_data), 32'hDEADBEEF);
      drain();

      hard_reset();
      ch_valid = '1;
      evt_ready = 1;
      for (int c = 0; c < NH; c++) begin
         ch_data[c*DW +: DW] = $urandom;
         cnt[c] = 0;
      end
      for (int i = 0; i < 100; i++) begin
         step("fair");
         chk("fair.order", 64'(obs_grant), 64'd1 << (i % NH));
         for (int c = 0; c < NH; c++) if (obs_grant[c]) cnt[c]++;
         if (last_g >= 0) ch_data[last_g*DW +: DW] = $urandom;
      end
      for (int c = 0; c < NH; c++) chk("fair.count", 64'(cnt[c]), 25);
      drain();

      hard_reset();
      nxt = 0;
      ch_valid = 4'b0010;
      ch_data[DW +: DW] = 0;
      for (int i = 0; i < 24; i++) begin
         step("full.fill");
         if (obs_grant[1]) begin
            nxt++;
            ch_data[DW +: DW] = nxt;
         end
      end
      chk("full.accepted", 64'(nxt), 16);
      chk("full.count", 64'(fifo_count), 16);
      chk("full.ready", 64'(ch_ready), 0);
      evt_ready = 1;
      exp_seq = 0;
      for (int i = 0; i < 200 && !(nxt == 32 && q.size() == 0); i++) begin
         if (nxt == 32) ch_valid = '0;
         step("full.drain");
         if (obs_grant[1]) begin
            nxt++;
            ch_data[DW +: DW] = nxt;
         end
         if (obs_pop) begin
            chk("full.order", 64'(obs_data), 64'(exp_seq));
            exp_seq++;
         end
      end
      chk("full.total", 64'(exp_seq), 32);
      drain();

      hard_reset();
      ch_valid = 4'b0001;
      ch_data[0 +: DW] = $urandom;
      for (int i = 0; i < 5; i++) begin
         step("pp.fill");
         ch_data[0 +: DW] = $urandom;
      end
      chk("pp.pre", 64'(fifo_count), 5);
      evt_ready = 1;
      step("pp.both");
      chk("pp.count", 64'(fifo_count), 5);
      for (int i = 0; i < 3*DEPTH + 4; i++) begin
         ch_data[0 +: DW] = $urandom;
         step("pp.wrap");
      end
      drain();

      start = 1;
      step("done.start");
      start = 0;
      n = 0;
      for (int i = 1; i <= 30 && n == 0; i++) begin
         step("done.wait");
         if (obs_done) n = i;
      end
      chk("done.latency", 64'(n), IDLE + 1);
      ch_valid = 4'b0100;
      ch_data[2*DW +: DW] = $urandom;
      step("done.pulse");
      ch_valid = '0;
      step("done.drop");
      chk("done.dropped", 64'(obs_done), 0);
      n = 0;
      for (int i = 1; i <= 30 && n == 0; i++) begin
         step("done.rewait");
         if (obs_done) n = i;
      end
      chk("done.rearm", 64'(n), IDLE + 1);

      evt_ready = 0;
      ch_valid = 4'b1000;
      for (int i = 0; i < 7; i++) begin
         ch_data[3*DW +: DW] = $urandom;
         step("rs.fill");
      end
      chk("rs.pre", 64'(fifo_count), 7);
      ch_valid = '0;
      rst_n = 0;
      #1;
      chk("rs.valid", 64'(evt_valid), 0);
      chk("rs.count", 64'(fifo_count), 0);
      chk("rs.done", 64'(ok_done), 0);
      model_reset();
      @(negedge okClk);
      rst_n = 1;
      @(posedge okClk);
      #1;
      v = $urandom;
      ch_valid = 4'b0100;
      ch_data[2*DW +: DW] = v;
      evt_ready = 1;
      step("rs.push");
      ch_valid = '0;
      step("rs.first");
      chk("rs.first_data", 64'(obs_data), 64'(v));

      start = 1;
      step("rand.start");
      start = 0;
      for (int b = 0; b < 40; b++) begin
         len = $urandom_range(5, 30);
         pct = (b % 3 == 2) ? 0 : $urandom_range(20, 90);
         rdp = $urandom_range(20, 100);
         for (int i = 0; i < len; i++) begin
            refresh(pct);
            evt_ready = $urandom_range(99) < rdp;
            start = $urandom_range(99) < 3;
            step("rand");
         end
      end
      start = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ok_multi_host_collector.md
# ok_multi_host_collector

Parametrised successor to the dual-host simulation wrapper. It accepts transaction records from NUM_HOSTS independent host channels, merges them through a round-robin arbiter into one shared FIFO tagged with channel number, and generates a real `ok_done` from a quiescence detector instead of a constant. It sits between the per-host simulation models and the testbench scoreboard.

## Interface
Parameters:
- NUM_HOSTS, 2, number of host channels; legal range 1–8.
- DATA_W, 32, width of each channel record.
- FIFO_DEPTH, 16, shared FIFO depth; must be a power of two and at least 2.
- IDLE_CYCLES, 8, consecutive quiet cycles required before `ok_done`; at least 1.
- CH_W, derived, equal to max(1, $clog2(NUM_HOSTS)).

Ports:
- okClk, in, 1, single clock; all state changes on the rising edge.
- rst_n, in, 1, reset, asynchronous and active-low.
- ch_valid, in, NUM_HOSTS, per-channel record valid.
- ch_data, in, NUM_HOSTS*DATA_W, per-channel record; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_ready, out, NUM_HOSTS, one-hot grant; a record transfers when both valid and ready are high.
- start, in, 1, one-cycle pulse that arms the done detector.
- evt_valid, out, 1, FIFO head is valid.
- evt_data, out, DATA_W, FIFO head data.
- evt_chan, out, CH_W, channel that sourced the FIFO head.
- evt_ready, in, 1, consumer pop.
- fifo_count, out, $clog2(FIFO_DEPTH)+1, current occupancy.
- ok_done, out, 1, all channels have been quiet for IDLE_CYCLES after `start`.

## Operation
**Arbiter**
- The arbiter is round-robin with pointer `rr`.
- It grants the lowest-index channel i with ch_valid[i] set, searching from `rr` upward with wrap-around.
- It grants nothing when fifo_count == FIFO_DEPTH. There is no full-bypass, even when a pop happens in the same cycle.
- After a grant to channel i, `rr` becomes (i+1) mod NUM_HOSTS. `rr` is unchanged when there is no grant.
- A channel holds ch_valid and ch_data stable until it is granted. Deasserting valid before grant is legal, and the record is lost.

**FIFO**
- Each entry stores {chan, data}.
- Read and write pointers are $clog2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
- Push and pop in the same cycle are allowed and leave fifo_count unchanged.
- A pop when empty is ignored.

**Done FSM: IDLE, RUN, DONE**
- IDLE → RUN on `start`. The idle counter clears on entry.
- In RUN, the idle counter increments when the cycle is quiet and clears to 0 otherwise. A cycle is quiet when ch_valid == 0, fifo_count == 0 and no push is occurring.
- RUN → DONE when the counter reaches IDLE_CYCLES. The counter saturates at that value.
- In DONE, `ok_done` = 1.
- DONE → RUN on `start`, or on any ch_valid bit. The counter clears on that transition.
- `start` in RUN restarts the count at 0.
- `ok_done` is a registered output and is 1 only in DONE.

**Reset values**
- ch_ready = 0, evt_valid = 0, evt_data = 0, evt_chan = 0, fifo_count = 0, ok_done = 0.
- FSM in IDLE, rr = 0.
- Reset asserted mid-operation discards all FIFO contents immediately, without waiting for a clock edge.

## Timing
- ch_ready is combinational from ch_valid, rr and fifo_count.
- Write latency: a record granted in cycle N appears as evt_valid/evt_data in cycle N+1 if the FIFO was empty.
- evt_data and evt_chan are first-word-fall-through. They change only after a pop, or on the first push into an empty FIFO.
- fifo_count updates one cycle after the push or pop edge.
- The earliest `ok_done` is IDLE_CYCLES+1 cycles after a `start` with no traffic.

## Structure
- Shared package `ok_sim_pkg` holds:
  - fsm state enum `done_state_t`;
  - helper function `clog2_min1`;
  - record struct `{chan, data}` parametrised through localparams.
- One sub-module: `ok_sync_fifo` (parameters DATA_W, DEPTH). It contains the storage, the pointers and fifo_count.
- The arbiter and FSM stay in the top module.

## Test plan
- **Single record:** NUM_HOSTS=2. ch0 sends 0xDEADBEEF with evt_ready=1. Required: ch_ready[0] high the same cycle; evt_valid=1, evt_data=0xDEADBEEF, evt_chan=0 the next cycle.
- **Fairness:** NUM_HOSTS=4, all channels continuously valid, consumer always ready. Required: grant order 0,1,2,3,0,… and exactly 25 records from each channel after 100 grants.
- **Full:** FIFO_DEPTH=16, evt_ready=0, ch1 streams 0x00..0x20. Required: 16 records accepted, then ch_ready=0 and fifo_count=16. After releasing evt_ready, records 0x00..0x1F are received in order with no loss or duplication.
- **Simultaneous push/pop:** at fifo_count=5, push and pop in the same cycle. Required: fifo_count stays 5. Wrap pointers across 3×DEPTH transfers and check data ordering.
- **Done detector:** IDLE_CYCLES=8, pulse `start`, no traffic. Required: ok_done rises on cycle 9. Then a ch_valid pulse drops ok_done the next cycle, and it re-asserts 8 quiet cycles after the FIFO drains.
- **Reset mid-stream:** assert rst_n=0 with 7 records queued. Required: evt_valid, fifo_count and ok_done are 0 before the next edge. After release, the first record delivered is the first one pushed after reset.
